// File: rtl/dna_port_emulator.sv
// Behavioural stand-in for a device-DNA port: a loadable ID register and a
// shift register read MSB-first, with sticky protocol-error flags.
module dna_port_emulator #(
    parameter int                    DNA_LENGTH = 57,
    parameter logic [DNA_LENGTH-1:0] DNA_VALUE  = 57'h123456789abcdef,
    parameter int                    CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  port_read,
    input  logic                  port_shift,
    input  logic                  port_din,
    output logic                  port_dout,
    input  logic                  id_wr,
    input  logic [DNA_LENGTH-1:0] id_wdata,
    input  logic                  err_clr,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  shift_count,
    output logic                  err_no_load,
    output logic                  err_collision,
    output logic                  err_overrun
);

    typedef enum logic [1:0] {
        S_EMPTY     = 2'd0,
        S_READY     = 2'd1,
        S_SHIFTING  = 2'd2,
        S_EXHAUSTED = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LEN = CNT_WIDTH'(DNA_LENGTH);

    generate
        if ((2 ** CNT_WIDTH) - 1 < DNA_LENGTH) begin : g_bad_cnt_width
            $error("CNT_WIDTH too small to count DNA_LENGTH shifts");
        end
    endgenerate

    logic [DNA_LENGTH-1:0] r_id;
    logic [DNA_LENGTH-1:0] r_sr;
    logic [CNT_WIDTH-1:0]  r_cnt;
    state_t                r_state;
    logic                  r_err_no_load;
    logic                  r_err_collision;
    logic                  r_err_overrun;

    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_id            <= DNA_VALUE;
            r_sr            <= '0;
            r_cnt           <= '0;
            r_state         <= S_EMPTY;
            r_err_no_load   <= 1'b0;
            r_err_collision <= 1'b0;
            r_err_overrun   <= 1'b0;
        end else begin
            // Clear first so that a same-cycle setting event below wins.
            if (err_clr) begin
                r_err_no_load   <= 1'b0;
                r_err_collision <= 1'b0;
                r_err_overrun   <= 1'b0;
            end

            if (id_wr) begin
                r_id <= id_wdata;
            end

            if (port_read) begin
                r_sr    <= id_wr ? id_wdata : r_id;
                r_cnt   <= '0;
                r_state <= S_READY;
                if (port_shift) begin
                    r_err_collision <= 1'b1;
                end
            end else if (port_shift) begin
                if (r_state == S_EMPTY) begin
                    r_err_no_load <= 1'b1;
                end else begin
                    r_sr  <= {r_sr[DNA_LENGTH-2:0], port_din};
                    r_cnt <= w_cnt_inc;
                    if (r_state == S_EXHAUSTED) begin
                        r_err_overrun <= 1'b1;
                    end else if (w_cnt_inc == CNT_LEN) begin
                        r_state <= S_EXHAUSTED;
                    end else begin
                        r_state <= S_SHIFTING;
                    end
                end
            end
        end
    end

    assign port_dout     = r_sr[DNA_LENGTH-1];
    assign state         = r_state;
    assign shift_count   = r_cnt;
    assign err_no_load   = r_err_no_load;
    assign err_collision = r_err_collision;
    assign err_overrun   = r_err_overrun;

endmodule

// File: doc/dna_port_emulator.md
DNA_PORT_EMULATOR -- requirements
Module: dna_port_emulator

Parameters
REQ-001 The block SHALL have parameter DNA_LENGTH, default 'd57, giving the ID width in bits.
REQ-002 The block SHALL have parameter DNA_VALUE, default 57'h123456789abcdef, giving the ID loaded at reset.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 'd6, giving the shift_count width; it SHALL satisfy 2^CNT_WIDTH-1 >= DNA_LENGTH.

Interface
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; every port is synchronous to its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port port_read, input, 1 bit: DNA_PORT READ; high loads the ID into the shift register.
REQ-007 The block SHALL have port port_shift, input, 1 bit: DNA_PORT SHIFT; high shifts one bit.
REQ-008 The block SHALL have port port_din, input, 1 bit: DNA_PORT DIN, shifted into the LSB.
REQ-009 The block SHALL have port port_dout, output, 1 bit: DNA_PORT DOUT, equal to the shift-register MSB.
REQ-010 The block SHALL have port id_wr, input, 1 bit: one-cycle strobe that overwrites the ID register.
REQ-011 The block SHALL have port id_wdata, input, DNA_LENGTH bits: the new ID value.
REQ-012 The block SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-013 The block SHALL have port state, output, 2 bits: EMPTY=0, READY=1, SHIFTING=2, EXHAUSTED=3.
REQ-014 The block SHALL have port shift_count, output, CNT_WIDTH bits: shifts since the last load.
REQ-015 The block SHALL have port err_no_load, output, 1 bit: sticky; set by a shift in state EMPTY.
REQ-016 The block SHALL have port err_collision, output, 1 bit: sticky; set when port_read and port_shift are high together.
REQ-017 The block SHALL have port err_overrun, output, 1 bit: sticky; set by a shift in state EXHAUSTED.

Function
REQ-018 The shift register (sr) SHALL drive port_dout from sr[DNA_LENGTH-1] combinationally from registered state.
REQ-019 When port_read=1, the block SHALL set sr to the ID register, shift_count to 0 and state to READY; READ takes priority over SHIFT.
REQ-020 When port_read=1 and id_wr=1 in the same cycle, sr SHALL load id_wdata (write-through), and the ID register SHALL also update to id_wdata.
REQ-021 When port_read=0 and port_shift=1 in any state other than EMPTY, the block SHALL set sr to {sr[DNA_LENGTH-2:0], port_din}.
REQ-022 On such a shift, shift_count SHALL increment and saturate at 2^CNT_WIDTH-1.
REQ-023 When port_read=0 and port_shift=1 in state EMPTY, sr SHALL stay all-zero, shift_count SHALL stay 0, and err_no_load SHALL be set.
REQ-024 State transitions SHALL be: READY -> SHIFTING on the first shift.
REQ-025 SHIFTING -> EXHAUSTED on the shift that brings shift_count to DNA_LENGTH.
REQ-026 EXHAUSTED SHALL persist under further shifts (each sets err_overrun) until the next port_read.
REQ-027 Any state SHALL go to READY on port_read.
REQ-028 With port_din tied to port_dout, sr after DNA_LENGTH shifts SHALL equal the loaded ID (circular).
REQ-029 id_wr SHALL update only the ID register; sr contents and state SHALL be unchanged unless port_read is also high.
REQ-030 err_collision SHALL be set on any cycle with port_read=1 and port_shift=1; the load proceeds as in REQ-019.
REQ-031 Error flags SHALL clear on err_clr=1.
REQ-032 When err_clr=1 and a setting event occur in the same cycle, the flag SHALL remain set (set wins).
REQ-033 The latency from a port_read or port_shift edge to the new port_dout SHALL be one clock.

Reset
REQ-034 On reset=0, asynchronously and immediately: sr SHALL be 0 and port_dout SHALL be 0.
REQ-035 On reset=0: the ID register SHALL be DNA_VALUE.
REQ-036 On reset=0: state SHALL be EMPTY and shift_count SHALL be 0.
REQ-037 On reset=0: all error flags SHALL be 0.
REQ-038 A reset asserted mid-shift SHALL abort the sequence; a port_read is required before valid data is available again.

Verification
REQ-039 Reset, then port_read for 1 cycle, then 57 cycles of port_shift with port_din=port_dout -> port_dout sequence equals 57'h123456789abcdef MSB first; state=EXHAUSTED, shift_count=57, no errors.
REQ-040 Reset, then 3 shifts with no load -> port_dout=0 throughout, state=EMPTY, shift_count=0, err_no_load=1.
REQ-041 Load, then 10 shifts, then port_read and port_shift together -> sr reloaded, shift_count=0, state=READY, err_collision=1; err_clr then clears it.
REQ-042 id_wr with 57'h1, then load, then 57 shifts -> 56 zeros then a 1; a fresh reset restores DNA_VALUE.
REQ-043 Load, then 60 shifts -> err_overrun set on shift 58, shift_count=60, state=EXHAUSTED.
REQ-044 Load, then 20 shifts, then reset low mid-cycle -> outputs zero before the next clock edge, state=EMPTY, ID register=DNA_VALUE.
